// File: rtl/jtframe_6809_shram_arb.sv
// Two-master arbiter (6809 CPU bus + req/ack SUB port) for one single-port synchronous RAM.
// Optional contention-stall counter: define JTFRAME_SHRAM_ARB_STATS_EN.
module jtframe_6809_shram_arb #(
    parameter int AW        = 11,
    parameter bit CPU_FIRST = 1'b1
) (
    input  logic          rstn,
    input  logic          clk,
    // 6809 side
    input  logic          cpu_cs,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_dout,
    output logic [7:0]    cpu_din,
    output logic          cpu_busy,
    // SUB side
    input  logic          sub_req,
    input  logic          sub_we,
    input  logic [AW-1:0] sub_addr,
    input  logic [7:0]    sub_dout,
    output logic [7:0]    sub_din,
    output logic          sub_ack,
    // RAM side
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [7:0]    ram_data,
    input  logic [7:0]    ram_q,
`ifdef JTFRAME_SHRAM_ARB_STATS_EN
    input  logic          stall_clr,
    output logic [15:0]   stall_cnt,
`endif
    output logic [1:0]    dbg_state_o
);

    // Handshakes: cpu_cs is a level held until cpu_busy falls; cpu_cs must go low
    // for at least one clk before the next CPU access. sub_req is a level held
    // until the one-clk sub_ack pulse; a sub_req still high in the clk after the
    // ack is taken as a new request.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        CAP  = 2'd2
    } state_t;

    state_t          state_q;
    logic            gnt_sub_q;
    logic            acc_we_q;
    logic            last_sub_q;
    logic            cpu_done_q;
    logic [7:0]      cpu_din_q;
    logic [7:0]      sub_din_q;
    logic            sub_ack_q;
    logic [AW-1:0]   ram_addr_q;
    logic            ram_we_q;
    logic [7:0]      ram_data_q;

    logic            cpu_pend;
    logic            sub_pend;
    logic            gnt_sub_d;
    logic            we_d;
    logic [AW-1:0]   addr_d;
    logic [7:0]      data_d;

    always_comb begin
        cpu_pend  = cpu_cs & ~cpu_done_q;
        sub_pend  = sub_req & ~sub_ack_q;
        // On a tie the master that was not served last wins.
        gnt_sub_d = sub_pend & (~cpu_pend | ~last_sub_q);
        we_d      = gnt_sub_d ? sub_we   : cpu_we;
        addr_d    = gnt_sub_d ? sub_addr : cpu_addr;
        data_d    = gnt_sub_d ? sub_dout : cpu_dout;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            gnt_sub_q  <= 1'b0;
            acc_we_q   <= 1'b0;
            // Reset as if the other master had just been served, so CPU_FIRST
            // decides the first tie.
            last_sub_q <= CPU_FIRST;
            cpu_done_q <= 1'b0;
            cpu_din_q  <= 8'h00;
            sub_din_q  <= 8'h00;
            sub_ack_q  <= 1'b0;
            ram_addr_q <= '0;
            ram_we_q   <= 1'b0;
            ram_data_q <= 8'h00;
        end else begin
            ram_we_q  <= 1'b0;
            sub_ack_q <= 1'b0;
            if (!cpu_cs) cpu_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu_pend || sub_pend) begin
                        state_q    <= ACC;
                        gnt_sub_q  <= gnt_sub_d;
                        last_sub_q <= gnt_sub_d;
                        acc_we_q   <= we_d;
                        ram_we_q   <= we_d;
                        ram_addr_q <= addr_d;
                        ram_data_q <= data_d;
                    end
                end
                ACC: begin
                    state_q <= CAP;
                end
                CAP: begin
                    state_q <= IDLE;
                    if (gnt_sub_q) begin
                        if (!acc_we_q) sub_din_q <= ram_q;
                        sub_ack_q <= 1'b1;
                    end else begin
                        if (!acc_we_q) cpu_din_q <= ram_q;
                        cpu_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cpu_busy    = cpu_cs & ~cpu_done_q;
    assign cpu_din     = cpu_din_q;
    assign sub_din     = sub_din_q;
    assign sub_ack     = sub_ack_q;
    assign ram_addr    = ram_addr_q;
    assign ram_we      = ram_we_q;
    assign ram_data    = ram_data_q;
    assign dbg_state_o = state_q;

`ifdef JTFRAME_SHRAM_ARB_STATS_EN
    logic [15:0] stall_cnt_q;
    logic        cap_cpu;

    // The CPU's own capture clk is not a stall; everything else with busy high is.
    assign cap_cpu = (state_q == CAP) & ~gnt_sub_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_q <= 16'h0000;
        end else if (stall_clr) begin
            stall_cnt_q <= 16'h0000;
        end else if (cpu_busy && !cap_cpu && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'h0001;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_jtframe_6809_shram_arb.sv
// Directed self-checking bench for jtframe_6809_shram_arb with a behavioural synchronous RAM.
module tb_jtframe_6809_shram_arb;

    localparam int AW = 11;

    logic          rstn;
    logic          clk;
    logic          cpu_cs;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_dout;
    logic [7:0]    cpu_din;
    logic          cpu_busy;
    logic          sub_req;
    logic          sub_we;
    logic [AW-1:0] sub_addr;
    logic [7:0]    sub_dout;
    logic [7:0]    sub_din;
    logic          sub_ack;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_data;
    logic [7:0]    ram_q;
    logic [1:0]    dbg_state;
`ifdef JTFRAME_SHRAM_ARB_STATS_EN
    logic          stall_clr;
    logic [15:0]   stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:(1<<AW)-1];

    jtframe_6809_shram_arb #(.AW(AW), .CPU_FIRST(1'b1)) dut (
        .rstn        (rstn),
        .clk         (clk),
        .cpu_cs      (cpu_cs),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_dout    (cpu_dout),
        .cpu_din     (cpu_din),
        .cpu_busy    (cpu_busy),
        .sub_req     (sub_req),
        .sub_we      (sub_we),
        .sub_addr    (sub_addr),
        .sub_dout    (sub_dout),
        .sub_din     (sub_din),
        .sub_ack     (sub_ack),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_data    (ram_data),
        .ram_q       (ram_q),
`ifdef JTFRAME_SHRAM_ARB_STATS_EN
        .stall_clr   (stall_clr),
        .stall_cnt   (stall_cnt),
`endif
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // single-port synchronous RAM, read data one clk after the address
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // driver: one CPU access from IDLE; returns busy clks, write strobes, ACC address
    task automatic cpu_access(input logic we, input logic [AW-1:0] addr, input logic [7:0] data,
                              output int busy_cnt, output int we_cnt, output logic [AW-1:0] acc_addr);
        busy_cnt = 0;
        we_cnt   = 0;
        acc_addr = '0;
        cpu_cs   = 1'b1;
        cpu_we   = we;
        cpu_addr = addr;
        cpu_dout = data;
        #1;
        for (int i = 0; i < 10; i++) begin
            if (!cpu_busy) break;
            busy_cnt++;
            if (ram_we) we_cnt++;
            if (i == 1) acc_addr = ram_addr;
            step();
        end
        cpu_cs = 1'b0;
        step();
    endtask

    // driver: one SUB access from IDLE; returns ack pulses and write strobes seen in 6 clks
    task automatic sub_access(input logic we, input logic [AW-1:0] addr, input logic [7:0] data,
                              output int ack_cnt, output int we_cnt);
        ack_cnt  = 0;
        we_cnt   = 0;
        sub_req  = 1'b1;
        sub_we   = we;
        sub_addr = addr;
        sub_dout = data;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ram_we) we_cnt++;
            if (sub_ack) begin
                ack_cnt++;
                sub_req = 1'b0;
            end
        end
        sub_req = 1'b0;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        cpu_cs = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_dout = 8'h00;
        sub_req = 1'b0; sub_we = 1'b0; sub_addr = '0; sub_dout = 8'h00;
`ifdef JTFRAME_SHRAM_ARB_STATS_EN
        stall_clr = 1'b0;
`endif
        step();
        step();
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        checks++; if (cpu_din !== 8'h00) begin errors++; $display("FAIL reset_cpu_din: got %h want 00", cpu_din); end
        checks++; if (sub_din !== 8'h00) begin errors++; $display("FAIL reset_sub_din: got %h want 00", sub_din); end
        checks++; if (sub_ack !== 1'b0) begin errors++; $display("FAIL reset_sub_ack: got %b want 0", sub_ack); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
        checks++; if (ram_addr !== '0) begin errors++; $display("FAIL reset_ram_addr: got %h want 000", ram_addr); end
        checks++; if (ram_data !== 8'h00) begin errors++; $display("FAIL reset_ram_data: got %h want 00", ram_data); end
        checks++; if (cpu_busy !== 1'b0) begin errors++; $display("FAIL reset_busy_idle: got %b want 0", cpu_busy); end
        cpu_cs = 1'b1;
        #1;
        checks++; if (cpu_busy !== 1'b1) begin errors++; $display("FAIL reset_busy_follows_cs: got %b want 1", cpu_busy); end
        cpu_cs = 1'b0;
        #1;
        rstn = 1'b1;
        step();
    endtask

    task automatic test_cpu_write();
        int bc, wc;
        logic [AW-1:0] aa;
        cpu_access(1'b1, 11'h123, 8'h5A, bc, wc, aa);
        checks++; if (bc !== 3) begin errors++; $display("FAIL cpu_wr_busy: got %0d want 3", bc); end
        checks++; if (wc !== 1) begin errors++; $display("FAIL cpu_wr_strobe: got %0d want 1", wc); end
        checks++; if (mem[11'h123] !== 8'h5A) begin errors++; $display("FAIL cpu_wr_ram: got %h want 5a", mem[11'h123]); end
        checks++; if (cpu_din !== 8'h00) begin errors++; $display("FAIL cpu_wr_din_kept: got %h want 00", cpu_din); end
    endtask

    task automatic test_cpu_read();
        int bc, wc;
        logic [AW-1:0] aa;
        cpu_access(1'b0, 11'h123, 8'hFF, bc, wc, aa);
        checks++; if (bc !== 3) begin errors++; $display("FAIL cpu_rd_busy: got %0d want 3", bc); end
        checks++; if (wc !== 0) begin errors++; $display("FAIL cpu_rd_strobe: got %0d want 0", wc); end
        checks++; if (aa !== 11'h123) begin errors++; $display("FAIL cpu_rd_acc_addr: got %h want 123", aa); end
        checks++; if (cpu_din !== 8'h5A) begin errors++; $display("FAIL cpu_rd_din: got %h want 5a", cpu_din); end
    endtask

    task automatic test_sub_write_cpu_read();
        int ac, wc, bc, cwc;
        logic [AW-1:0] aa;
        sub_access(1'b1, 11'h010, 8'hC3, ac, wc);
        checks++; if (ac !== 1) begin errors++; $display("FAIL sub_wr_ack: got %0d want 1", ac); end
        checks++; if (wc !== 1) begin errors++; $display("FAIL sub_wr_strobe: got %0d want 1", wc); end
        checks++; if (mem[11'h010] !== 8'hC3) begin errors++; $display("FAIL sub_wr_ram: got %h want c3", mem[11'h010]); end
        cpu_access(1'b0, 11'h010, 8'h00, bc, cwc, aa);
        checks++; if (cpu_din !== 8'hC3) begin errors++; $display("FAIL sub_wr_cpu_rd: got %h want c3", cpu_din); end
        checks++; if (bc !== 3) begin errors++; $display("FAIL sub_wr_cpu_busy: got %0d want 3", bc); end
    endtask

    task automatic test_alternation();
        int n_cpu, n_sub, alt_err, last_ev, first_ev;
        logic [AW-1:0] first_addr;
        n_cpu = 0; n_sub = 0; alt_err = 0; last_ev = 0; first_ev = 0;
        first_addr = '0;
        apply_reset();
        cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h100;
        sub_req = 1'b1; sub_we = 1'b0; sub_addr = 11'h200;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (i == 1) first_addr = ram_addr;
            if (sub_ack) begin
                n_sub++;
                if (last_ev == 1) alt_err++;
                if (first_ev == 0) first_ev = 1;
                last_ev = 1;
            end
            if (cpu_cs && !cpu_busy) begin
                n_cpu++;
                if (last_ev == 2) alt_err++;
                if (first_ev == 0) first_ev = 2;
                last_ev = 2;
                cpu_cs = 1'b0;
            end else if (!cpu_cs) begin
                cpu_cs = 1'b1;
            end
            if (i == 60) begin
                sub_req = 1'b0;
                cpu_cs  = 1'b0;
            end
        end
        step();
        step();
        checks++; if (first_addr !== 11'h100) begin errors++; $display("FAIL alt_first_grant_addr: got %h want 100", first_addr); end
        checks++; if (first_ev !== 2) begin errors++; $display("FAIL alt_first_done: got %0d want 2 (cpu)", first_ev); end
        checks++; if (n_cpu !== 10) begin errors++; $display("FAIL alt_cpu_grants: got %0d want 10", n_cpu); end
        checks++; if (n_sub !== 10) begin errors++; $display("FAIL alt_sub_grants: got %0d want 10", n_sub); end
        checks++; if (alt_err !== 0) begin errors++; $display("FAIL alt_strict: got %0d repeats want 0", alt_err); end
    endtask

    task automatic test_cpu_mid_sub();
        int bc, acks, found;
        logic [AW-1:0] nxt_addr;
        bc = 0; acks = 0; found = 0; nxt_addr = '0;
        sub_req = 1'b1; sub_we = 1'b0; sub_addr = 11'h020;
        step();
        cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h123;
        #1;
        for (int i = 0; i < 12; i++) begin
            if (!cpu_busy) break;
            bc++;
            if (sub_ack) acks++;
            step();
        end
        cpu_cs = 1'b0;
        checks++; if (bc !== 5) begin errors++; $display("FAIL mid_busy_clks: got %0d want 5", bc); end
        checks++; if (bc > 6) begin errors++; $display("FAIL mid_busy_bound: got %0d want <=6", bc); end
        checks++; if (acks !== 1) begin errors++; $display("FAIL mid_sub_acks_while_busy: got %0d want 1", acks); end
        checks++; if (cpu_din !== 8'h5A) begin errors++; $display("FAIL mid_cpu_din: got %h want 5a", cpu_din); end
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 1) nxt_addr = ram_addr;
            if (sub_ack) begin
                found++;
                sub_req = 1'b0;
            end
        end
        sub_req = 1'b0;
        checks++; if (nxt_addr !== 11'h020) begin errors++; $display("FAIL mid_next_sub_addr: got %h want 020", nxt_addr); end
        checks++; if (found !== 1) begin errors++; $display("FAIL mid_next_sub_ack: got %0d want 1", found); end
    endtask

    task automatic test_reset_mid_access();
        int ac, wc;
        sub_access(1'b1, 11'h030, 8'h11, ac, wc);
        sub_req = 1'b1; sub_we = 1'b1; sub_addr = 11'h030; sub_dout = 8'h99;
        step();
        checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_we: got %b want 1", ram_we); end
        rstn = 1'b0;
        #1;
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_mid_we_drop: got %b want 0", ram_we); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_mid_state: got %0d want 0", dbg_state); end
        checks++; if (ram_addr !== '0) begin errors++; $display("FAIL rst_mid_addr: got %h want 000", ram_addr); end
        checks++; if (cpu_din !== 8'h00) begin errors++; $display("FAIL rst_mid_cpu_din: got %h want 00", cpu_din); end
        sub_req = 1'b0;
        step();
        checks++; if (sub_ack !== 1'b0) begin errors++; $display("FAIL rst_mid_no_ack: got %b want 0", sub_ack); end
        rstn = 1'b1;
        step();
        checks++; if (mem[11'h030] !== 8'h11) begin errors++; $display("FAIL rst_mid_no_write: got %h want 11", mem[11'h030]); end
        sub_access(1'b0, 11'h030, 8'h00, ac, wc);
        checks++; if (ac !== 1) begin errors++; $display("FAIL rst_post_ack: got %0d want 1", ac); end
        checks++; if (sub_din !== 8'h11) begin errors++; $display("FAIL rst_post_sub_din: got %h want 11", sub_din); end
    endtask

`ifdef JTFRAME_SHRAM_ARB_STATS_EN
    task automatic test_stats();
        stall_clr = 1'b1;
        step();
        stall_clr = 1'b0;
        for (int n = 0; n < 5; n++) begin
            sub_req = 1'b1; sub_we = 1'b0; sub_addr = 11'h040;
            step();
            step();
            cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h123;
            step();
            sub_req = 1'b0;
            step();
            step();
            step();
            cpu_cs = 1'b0;
            step();
        end
        checks++; if (stall_cnt !== 16'd15) begin errors++; $display("FAIL stats_count: got %0d want 15", stall_cnt); end
        stall_clr = 1'b1;
        step();
        stall_clr = 1'b0;
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL stats_clear: got %0d want 0", stall_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_sub_write_cpu_read();
        test_alternation();
        test_cpu_mid_sub();
        test_reset_mid_access();
`ifdef JTFRAME_SHRAM_ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
